// File: rtl/ifu_exec_sequencer_if.sv
// Fetch bus between the exec sequencer and instruction memory.
// master: request valid/addr out, ready/response in; slave: mirror.
interface ifu_exec_sequencer_if #(
  parameter int ADDR_W = 32
) ();
  logic              ifu_req_valid;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_req_ready;
  logic              ifu_resp_valid;
  logic [31:0]       ifu_resp_data;

  modport master (
    output ifu_req_valid,
    output ifu_req_addr,
    input  ifu_req_ready,
    input  ifu_resp_valid,
    input  ifu_resp_data
  );

  modport slave (
    input  ifu_req_valid,
    input  ifu_req_addr,
    output ifu_req_ready,
    output ifu_resp_valid,
    output ifu_resp_data
  );
endinterface

// File: rtl/ifu_exec_sequencer.sv
// Multi-cycle fetch/exec sequencer for the RV32 single-cycle datapath.
// Ports: clk, reset (sync, active-high), pc_in, ifu (fetch bus master),
// ist_out, commit, halted, instret, fetch_err.
// Optional: FETCH_TIMEOUT_EN adds a WAIT timeout that halts the core.
module ifu_exec_sequencer #(
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter int          TIMEOUT  = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [ADDR_W-1:0]           pc_in,
  ifu_exec_sequencer_if.master        ifu,
  output logic [31:0]                 ist_out,
  output logic                        commit,
  output logic                        halted,
  output logic [31:0]                 instret,
  output logic                        fetch_err
);

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              is_ebreak;
  logic              resp_take;
  logic              fetch_entry;
  logic              to_hit;

  assign is_ebreak = (ist_out == EBREAK);

  // Response is accepted only together with or after the handshake.
  assign resp_take =
    ((state == S_FETCH) && ifu.ifu_req_ready && ifu.ifu_resp_valid) ||
    ((state == S_WAIT) && ifu.ifu_resp_valid);

  assign fetch_entry = (state_nxt == S_FETCH) && (state != S_FETCH);

`ifdef FETCH_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] wait_cnt;

  // A response on the final count still wins.
  assign to_hit = (state == S_WAIT) && !ifu.ifu_resp_valid &&
                  (wait_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt  <= '0;
      fetch_err <= 1'b0;
    end else begin
      if (state != S_WAIT) wait_cnt <= '0;
      else                 wait_cnt <= wait_cnt + 1'b1;
      if (to_hit) fetch_err <= 1'b1;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (ifu.ifu_req_ready)
          state_nxt = ifu.ifu_resp_valid ? S_EXEC : S_WAIT;
      end
      S_WAIT: begin
        if (ifu.ifu_resp_valid) state_nxt = S_EXEC;
        else if (to_hit)        state_nxt = S_HALT;
      end
      S_EXEC:  state_nxt = is_ebreak ? S_HALT : S_FETCH;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    req_valid = 1'b0;
    commit    = 1'b0;
    halted    = 1'b0;
    unique case (state)
      S_FETCH: req_valid = 1'b1;
      S_EXEC:  commit    = !is_ebreak;
      S_HALT:  halted    = 1'b1;
      default: ;
    endcase
  end

  // Address is frozen for the whole FETCH stay, so the bus sees a
  // stable request even if pc_in moves underneath.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_addr <= '0;
      ist_out  <= NOP_INST;
      instret  <= '0;
    end else begin
      if (fetch_entry)       req_addr <= pc_in;
      if (resp_take)         ist_out  <= ifu.ifu_resp_data;
      if (state == S_EXEC)   instret  <= instret + 32'd1;
    end
  end

  assign ifu.ifu_req_valid = req_valid;
  assign ifu.ifu_req_addr  = req_addr;

endmodule

// File: tb/tb_ifu_exec_sequencer.sv
// Directed bench for ifu_exec_sequencer.
// Define FETCH_TIMEOUT_EN for both DUT and bench to cover the timeout.
module tb_ifu_exec_sequencer;

  logic        clk;
  logic        reset;
  logic [31:0] pc_in;
  logic [31:0] ist_out;
  logic        commit;
  logic        halted;
  logic [31:0] instret;
  logic        fetch_err;

  int compared;
  int mismatched;

  ifu_exec_sequencer_if #(.ADDR_W(32)) ifu ();

  ifu_exec_sequencer #(
    .ADDR_W  (32),
    .NOP_INST(32'h0000_0013),
    .TIMEOUT (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .pc_in    (pc_in),
    .ifu      (ifu),
    .ist_out  (ist_out),
    .commit   (commit),
    .halted   (halted),
    .instret  (instret),
    .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic rv,
                       input logic [31:0] d);
    ifu.ifu_req_ready  = rdy;
    ifu.ifu_resp_valid = rv;
    ifu.ifu_resp_data  = d;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    pc_in = 32'h8000_0000;
    drive(1'b0, 1'b0, 32'h0);

    // reset held two cycles
    tick();
    tick();
    chk("rst_valid",   {31'b0, ifu.ifu_req_valid}, 32'd0);
    chk("rst_addr",    ifu.ifu_req_addr, 32'd0);
    chk("rst_ist",     ist_out, 32'h0000_0013);
    chk("rst_commit",  {31'b0, commit}, 32'd0);
    chk("rst_halted",  {31'b0, halted}, 32'd0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_err",     {31'b0, fetch_err}, 32'd0);

    // release, same-cycle ready+resp
    reset = 1'b0;
    drive(1'b1, 1'b1, 32'h0050_0093);
    tick();
    chk("t1_valid", {31'b0, ifu.ifu_req_valid}, 32'd1);
    chk("t1_addr",  ifu.ifu_req_addr, 32'h8000_0000);
    chk("t1_nocommit", {31'b0, commit}, 32'd0);
    tick();
    chk("t1_commit", {31'b0, commit}, 32'd1);
    chk("t1_ist",    ist_out, 32'h0050_0093);
    chk("t1_exec_valid", {31'b0, ifu.ifu_req_valid}, 32'd0);
    drive(1'b0, 1'b0, 32'h0);
    pc_in = 32'h8000_0004;
    tick();
    chk("t1_instret", instret, 32'd1);
    chk("t1_post_commit", {31'b0, commit}, 32'd0);
    chk("t2_addr_new", ifu.ifu_req_addr, 32'h8000_0004);

    // ready delayed 3 cycles; early responses must be ignored
    pc_in = 32'hDEAD_0000;
    for (int i = 0; i < 4; i++) begin
      chk("t2_valid", {31'b0, ifu.ifu_req_valid}, 32'd1);
      chk("t2_addr",  ifu.ifu_req_addr, 32'h8000_0004);
      chk("t2_commit", {31'b0, commit}, 32'd0);
      if (i == 3) drive(1'b1, 1'b0, 32'h0);
      else        drive(1'b0, 1'b1, 32'hDEAD_BEEF);
      tick();
    end
    drive(1'b0, 1'b0, 32'h0);
    chk("t2_wait_valid", {31'b0, ifu.ifu_req_valid}, 32'd0);
    chk("t2_wait_commit", {31'b0, commit}, 32'd0);
    chk("t2_ist_kept", ist_out, 32'h0050_0093);
    tick();
    chk("t2_wait2_commit", {31'b0, commit}, 32'd0);
    drive(1'b0, 1'b1, 32'h00A0_0113);
    tick();
    chk("t2_commit", {31'b0, commit}, 32'd1);
    chk("t2_ist",    ist_out, 32'h00A0_0113);
    drive(1'b0, 1'b0, 32'h0);
    pc_in = 32'h8000_0008;
    tick();
    chk("t2_instret", instret, 32'd2);
    chk("t2_post_commit", {31'b0, commit}, 32'd0);
    chk("t3_addr", ifu.ifu_req_addr, 32'h8000_0008);

    // ebreak
    drive(1'b1, 1'b1, 32'h0010_0073);
    tick();
    chk("t3_commit", {31'b0, commit}, 32'd0);
    chk("t3_ist",    ist_out, 32'h0010_0073);
    chk("t3_halted_early", {31'b0, halted}, 32'd0);
    drive(1'b1, 1'b1, 32'h1111_1111);
    tick();
    chk("t3_halted",  {31'b0, halted}, 32'd1);
    chk("t3_instret", instret, 32'd3);
    for (int i = 0; i < 20; i++) begin
      chk("t3_no_req", {31'b0, ifu.ifu_req_valid}, 32'd0);
      tick();
    end
    chk("t3_halt_sticky", {31'b0, halted}, 32'd1);
    chk("t3_halt_commit", {31'b0, commit}, 32'd0);
    chk("t3_halt_ist", ist_out, 32'h0010_0073);

    // reset during WAIT with a response on the same edge
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    reset = 1'b0;
    pc_in = 32'h8000_0010;
    tick();
    drive(1'b1, 1'b0, 32'h0);
    tick();
    chk("t4_in_wait", {31'b0, ifu.ifu_req_valid}, 32'd0);
    reset = 1'b1;
    drive(1'b0, 1'b1, 32'h1234_5678);
    tick();
    chk("t4_ist",     ist_out, 32'h0000_0013);
    chk("t4_commit",  {31'b0, commit}, 32'd0);
    chk("t4_instret", instret, 32'd0);
    chk("t4_halted",  {31'b0, halted}, 32'd0);
    chk("t4_valid",   {31'b0, ifu.ifu_req_valid}, 32'd0);
    reset = 1'b0;
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk("t4_ist_idle", ist_out, 32'h0000_0013);
    chk("t4_commit_idle", {31'b0, commit}, 32'd0);
    tick();
    chk("t4_refetch", {31'b0, ifu.ifu_req_valid}, 32'd1);
    chk("t4_addr",    ifu.ifu_req_addr, 32'h8000_0010);
    drive(1'b1, 1'b1, 32'h0030_0193);
    tick();
    chk("t4_exec",     {31'b0, commit}, 32'd1);
    chk("t4_exec_ist", ist_out, 32'h0030_0193);
    drive(1'b0, 1'b0, 32'h0);
    pc_in = 32'h8000_0014;
    tick();
    chk("t4_instret1", instret, 32'd1);

    // instret wrap
    force dut.instret = 32'hFFFF_FFFF;
    #1;
    release dut.instret;
    drive(1'b1, 1'b1, 32'h0040_0213);
    tick();
    chk("t5_commit", {31'b0, commit}, 32'd1);
    drive(1'b0, 1'b0, 32'h0);
    tick();
    chk("t5_wrap",   instret, 32'd0);
    chk("t5_halted", {31'b0, halted}, 32'd0);
    chk("t5_refetch", {31'b0, ifu.ifu_req_valid}, 32'd1);

    // memory accepts but never responds
    drive(1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b0, 32'h0);
`ifdef FETCH_TIMEOUT_EN
    for (int i = 0; i < 4; i++) begin
      chk("t6_wait_err",    {31'b0, fetch_err}, 32'd0);
      chk("t6_wait_halt",   {31'b0, halted}, 32'd0);
      chk("t6_wait_commit", {31'b0, commit}, 32'd0);
      tick();
    end
    chk("t6_err",    {31'b0, fetch_err}, 32'd1);
    chk("t6_halted", {31'b0, halted}, 32'd1);
    chk("t6_commit", {31'b0, commit}, 32'd0);
    chk("t6_instret", instret, 32'd0);
    drive(1'b1, 1'b1, 32'h0050_0093);
    tick();
    chk("t6_stuck_commit", {31'b0, commit}, 32'd0);
    chk("t6_err_sticky", {31'b0, fetch_err}, 32'd1);
`else
    for (int i = 0; i < 100; i++) begin
      chk("t6_wait_valid",  {31'b0, ifu.ifu_req_valid}, 32'd0);
      chk("t6_wait_commit", {31'b0, commit}, 32'd0);
      chk("t6_wait_halt",   {31'b0, halted}, 32'd0);
      chk("t6_wait_err",    {31'b0, fetch_err}, 32'd0);
      tick();
    end
    drive(1'b0, 1'b1, 32'h0060_0293);
    tick();
    chk("t6_late_commit", {31'b0, commit}, 32'd1);
    chk("t6_late_ist",    ist_out, 32'h0060_0293);
    chk("t6_err",         {31'b0, fetch_err}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ifu_exec_sequencer.md
Name: ifu_exec_sequencer

Overview:
- Multi-cycle sequencer in front of the RV32 single-cycle datapath.
- Fetches each instruction over a valid/ready request + valid response memory interface and presents it to the decode/execute logic.
- Gates the PC register and register-file write enables so that exactly one instruction commits per fetch.
- Halts on ebreak and counts retired instructions.

Parameters:
- ADDR_W, 32, width of PC and fetch address.
- NOP_INST, 32'h00000013, instruction driven on ist_out while nothing valid is latched (addi x0,x0,0).
- TIMEOUT, 255, max cycles in WAIT before error (only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- pc_in  in  ADDR_W  current PC from datapath PC register
- ifu_req_valid  out  1  fetch request valid
- ifu_req_addr  out  ADDR_W  fetch address
- ifu_req_ready  in  1  memory accepts request
- ifu_resp_valid  in  1  instruction data valid
- ifu_resp_data  in  32  fetched instruction word
- ist_out  out  32  latched instruction to decoder
- commit  out  1  one-cycle pulse; ANDed into PC write enable and rf_wen by datapath
- halted  out  1  sticky, set after ebreak retires
- instret  out  32  retired instruction count
- fetch_err  out  1  sticky fetch timeout flag (0 when feature compiled out)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- Reset values: state=IDLE, ifu_req_valid=0, ifu_req_addr=0, ist_out=NOP_INST, commit=0, halted=0, instret=0, fetch_err=0. Reset is evaluated only on a clk edge.
- States: IDLE, FETCH, WAIT, EXEC, HALT.
- IDLE:
  - Outputs idle.
  - Unconditionally moves to FETCH next cycle (one settle cycle after reset).
  - ifu_resp_valid is ignored.
- FETCH:
  - ifu_req_valid=1. ifu_req_addr is captured from pc_in on entry and held stable while valid && !ready.
  - On ifu_req_ready=1 (handshake): if ifu_resp_valid=1 in the same cycle, latch ifu_resp_data into ist_out and go to EXEC; otherwise go to WAIT.
  - ifu_resp_valid before the handshake is ignored.
- WAIT:
  - ifu_req_valid=0.
  - On ifu_resp_valid=1: latch ifu_resp_data into ist_out, go to EXEC.
- EXEC (exactly one cycle):
  - commit=1, except commit=0 when ist_out==32'h00100073 (ebreak).
  - instret increments by 1, including for ebreak; wraps from 32'hFFFFFFFF to 0.
  - Next state: HALT if ebreak, else FETCH.
  - pc_in is sampled again on entry to FETCH, so the new PC is used.
- HALT:
  - Sticky until reset. halted=1, commit=0, ifu_req_valid=0.
  - ist_out holds the ebreak word; responses are ignored.
- Latency: minimum 2 cycles per instruction (FETCH with same-cycle ready+resp, then EXEC). Each cycle of ready or response delay adds one cycle.
- commit is never asserted in any state other than EXEC, and never on two consecutive cycles.
- Reset mid-operation:
  - Any state returns to IDLE.
  - An outstanding response is discarded: a response arriving in IDLE/FETCH-before-handshake is dropped.
  - instret and halted clear.
- Simultaneous reset and ifu_resp_valid: reset wins, nothing latched.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - 8-bit (or clog2(TIMEOUT+1)-bit) counter clears on WAIT entry and increments each WAIT cycle.
  - If the count reaches TIMEOUT with no response: set fetch_err=1 (sticky), set halted=1, go to HALT, no commit.
  - A response in the same cycle the count hits TIMEOUT takes priority (normal EXEC).
- Not defined: no counter; WAIT waits indefinitely; fetch_err tied to 0.

Test Plan:
- Reset held 2 cycles, then released with ready=1 and same-cycle resp=32'h00500093 -> ifu_req_valid rises the 2nd cycle after release with addr=32'h80000000 (pc_in). Next cycle commit=1 and ist_out=32'h00500093. instret=1 after that edge.
- ready delayed 3 cycles, resp 2 cycles after handshake -> ifu_req_addr stable for all 4 valid cycles. Exactly one commit pulse. Instruction takes 7 cycles.
- Fetch returns 32'h00100073 -> EXEC with commit=0. instret increments. halted=1 next cycle and stays 1. No further ifu_req_valid over 20 cycles.
- Reset asserted during WAIT, resp=32'h12345678 arrives on the same edge -> state IDLE, ist_out=32'h00000013, no commit. Next fetch proceeds normally.
- instret preloaded via 2^32-1 retires (or force) -> one more retire gives instret=0, no halt.
- FETCH_TIMEOUT_EN, TIMEOUT=4, memory never responds -> fetch_err=1 and halted=1 after 4 WAIT cycles, commit never asserted. Without the macro: still in WAIT after 100 cycles, fetch_err=0.
